fifo_rd_packer: RTL and testbench

- Read-domain consumer of asynchronous_fifo.
- Drains FIFO bytes through the FIFO's r_en/empty/data_out read port and packs PACK_RATIO consecutive bytes into one word.
- Presents each word on a valid/ready stream toward the downstream datapath.
- A flush request emits a partial word with a byte-keep mask.

---
 rtl/fifo_rd_pkg.sv | 25 ++
 rtl/fifo_rd_packer_slot.sv | 47 ++++
 rtl/fifo_rd_packer.sv | 173 +++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side byte packer.
// Holds the flush FSM state enum and the byte-keep mask helper.
package fifo_rd_pkg;

  localparam int unsigned MAX_RATIO = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    EMIT
  } pk_state_e;

  // Mask with the low 'count' bits set.
  function automatic logic [MAX_RATIO-1:0] keep_mask(
    input logic [3:0] count
  );
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      m[i] = (32'(i) < 32'(count));
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_slot.sv
// rd_word_slot: single-entry output register for the packed word stream.
// Ports: clk_i/rst_i, load_i+data_i+keep_i in, ready_i, free_o, valid_o/data_o/keep_o out.
module rd_word_slot
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned K = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic [K-1:0] keep_i,
  input  logic         ready_i,
  output logic         free_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [K-1:0] keep_o
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic [K-1:0] keep_q;

  // Free when empty or being drained at this edge.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      if (load_i) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
        keep_q  <= keep_i;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains FIFO bytes and packs PACK_RATIO of them per word.
// Ports: r_clk/rrst, fifo_empty/fifo_data/fifo_r_en, flush, m_valid/m_ready/m_data/m_keep, flush_busy, byte_cnt.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter  int unsigned DATA_SIZE  = 8,
  parameter  int unsigned PACK_RATIO = 4,
  localparam int unsigned WORD_SIZE  = DATA_SIZE * PACK_RATIO,
  localparam int unsigned CW         = $clog2(PACK_RATIO + 1)
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_SIZE-1:0]  fifo_data,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_SIZE-1:0]  m_data,
  output logic [PACK_RATIO-1:0] m_keep,
  output logic                  flush_busy,
  output logic [CW-1:0]         byte_cnt
);

  localparam logic [CW-1:0] RATIO = CW'(PACK_RATIO);

  logic [PACK_RATIO-1:0][DATA_SIZE-1:0] lanes_q;
  logic [PACK_RATIO-1:0][DATA_SIZE-1:0] lanes_d;
  logic [PACK_RATIO-1:0][DATA_SIZE-1:0] lanes_cap;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_cap;
  logic [CW:0]   fill;

  logic      pend_q;
  pk_state_e state_q;
  pk_state_e state_d;
  logic      busy_q;
  logic      busy_d;
  logic      dwait_q;
  logic      dwait_d;
  logic      sent_q;
  logic      sent_d;

  logic                  slot_free;
  logic                  load_run;
  logic                  emit_ld;
  logic                  load;
  logic                  room;
  logic [WORD_SIZE-1:0]  ld_data;
  logic [PACK_RATIO-1:0] ld_keep;
  logic [MAX_RATIO-1:0]  km;
  logic                  unused_km;

  // Lanes as they stand after this edge's pending byte lands.
  always_comb begin
    lanes_cap = lanes_q;
    cnt_cap   = cnt_q;
    for (int i = 0; i < int'(PACK_RATIO); i++) begin
      if (pend_q && cnt_q == CW'(i)) begin
        lanes_cap[i] = fifo_data;
      end
    end
    if (pend_q) begin
      cnt_cap = cnt_q + CW'(1);
    end
  end

  assign fill = {1'b0, cnt_q} + (CW+1)'(pend_q);

  assign load_run = (state_q == RUN) && (cnt_cap == RATIO) && slot_free;
  assign emit_ld  = (state_q == EMIT) && !sent_q && slot_free;
  assign load     = load_run || emit_ld;

  // A word leaving the lanes at this edge frees lane 0 for the next read,
  // which keeps the stream at one byte per cycle.
  assign room = (fill < (CW+1)'(PACK_RATIO)) || load_run;

  assign fifo_r_en = !rrst && !fifo_empty && (state_q == RUN) && room;

  assign km        = keep_mask(4'(cnt_q));
  assign unused_km = ^km;
  assign ld_data   = lanes_cap;
  assign ld_keep   = load_run ? '1 : km[PACK_RATIO-1:0];

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    dwait_d = dwait_q;
    sent_d  = sent_q;
    lanes_d = lanes_cap;
    cnt_d   = cnt_cap;
    if (load) begin
      lanes_d = '0;
      cnt_d   = '0;
    end
    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
          busy_d  = 1'b1;
          dwait_d = 1'b1;
        end
      end
      DRAIN: begin
        // First cycle lets any in-flight read land; decide on the next.
        if (dwait_q) begin
          dwait_d = 1'b0;
        end else if (!pend_q) begin
          if (cnt_q == '0) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (emit_ld) begin
          sent_d = 1'b1;
        end else if (sent_q && m_valid && m_ready) begin
          state_d = RUN;
          busy_d  = 1'b0;
          sent_d  = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      state_q <= RUN;
      busy_q  <= 1'b0;
      dwait_q <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      pend_q  <= fifo_r_en && !fifo_empty;
      state_q <= state_d;
      busy_q  <= busy_d;
      dwait_q <= dwait_d;
      sent_q  <= sent_d;
    end
  end

  assign flush_busy = busy_q;
  assign byte_cnt   = cnt_q;

  rd_word_slot #(
    .W (WORD_SIZE),
    .K (PACK_RATIO)
  ) u_slot (
    .clk_i   (r_clk),
    .rst_i   (rrst),
    .load_i  (load),
    .data_i  (ld_data),
    .keep_i  (ld_keep),
    .ready_i (m_ready),
    .free_o  (slot_free),
    .valid_o (m_valid),
    .data_o  (m_data),
    .keep_o  (m_keep)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO read port.
// Checks streaming, backpressure, flushes, empty gaps and reset.
module tb_fifo_rd_packer;

  logic        r_clk = 1'b0;
  logic        rrst;
  logic        fifo_empty;
  logic [7:0]  fifo_data = '0;
  logic        fifo_r_en;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        flush_busy;
  logic [2:0]  byte_cnt;

  always #5 r_clk = ~r_clk;

  fifo_rd_packer #(
    .DATA_SIZE  (8),
    .PACK_RATIO (4)
  ) dut (
    .r_clk      (r_clk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .flush_busy (flush_busy),
    .byte_cnt   (byte_cnt)
  );

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int reads_acc = 0;
  int en_empty  = 0;
  int wcount    = 0;
  logic [35:0] words [0:63];

  always @(posedge r_clk) begin
    if (fifo_r_en && fifo_empty) en_empty <= en_empty + 1;
    if (fifo_r_en && !fifo_empty) reads_acc <= reads_acc + 1;
    if (m_valid && m_ready && !rrst) begin
      words[wcount[5:0]] <= {m_keep, m_data};
      wcount <= wcount + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (wcount < n && k < 200) begin
      @(negedge r_clk);
      k++;
    end
    check("word_arrival", 64'(wcount >= n), 64'd1);
  endtask

  int run, maxrun, bad, seen, w0, r0, busy_n, v_n;
  logic [7:0] gb [0:7];
  int gg [0:7];

  initial begin
    rrst    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge r_clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_keep", 64'(m_keep), 64'd0);
    check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    check("rst_flush_busy", 64'(flush_busy), 64'd0);
    check("rst_r_en", 64'(fifo_r_en), 64'd0);
    rrst = 1'b0;
    @(negedge r_clk);

    // Streaming at full rate.
    m_ready = 1'b1;
    w0 = wcount;
    for (int i = 1; i <= 8; i++) push(8'(i));
    run = 0;
    maxrun = 0;
    repeat (20) begin
      #1;
      if (fifo_r_en) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      @(negedge r_clk);
    end
    check("stream_r_en_run", 64'(maxrun), 64'd8);
    wait_words(w0 + 2);
    check("stream_w0", 64'(words[w0]), 64'hF_04030201);
    check("stream_w1", 64'(words[w0+1]), 64'hF_08070605);

    // Backpressure.
    m_ready = 1'b0;
    w0 = wcount;
    r0 = reads_acc;
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
    bad = 0;
    seen = 0;
    repeat (20) begin
      @(negedge r_clk);
      if (m_valid) begin
        seen = 1;
        if (m_data !== 32'h13121110 || m_keep !== 4'hF) bad++;
      end
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    check("bp_hold_stable", 64'(bad), 64'd0);
    check("bp_byte_cnt", 64'(byte_cnt), 64'd4);
    check("bp_r_en_low", 64'(fifo_r_en), 64'd0);
    check("bp_reads", 64'(reads_acc - r0), 64'd8);
    m_ready = 1'b1;
    wait_words(w0 + 3);
    check("bp_w0", 64'(words[w0]), 64'hF_13121110);
    check("bp_w1", 64'(words[w0+1]), 64'hF_17161514);
    check("bp_w2", 64'(words[w0+2]), 64'hF_1B1A1918);
    repeat (5) @(negedge r_clk);
    check("bp_word_count", 64'(wcount - w0), 64'd3);
    check("bp_fifo_drained", 64'(fifo_empty), 64'd1);

    // Partial flush.
    w0 = wcount;
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    repeat (6) @(negedge r_clk);
    check("pf_byte_cnt", 64'(byte_cnt), 64'd3);
    m_ready = 1'b0;
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    begin
      int k;
      k = 0;
      while (!m_valid && k < 20) begin
        @(negedge r_clk);
        k++;
      end
    end
    check("pf_valid", 64'(m_valid), 64'd1);
    check("pf_data", 64'(m_data), 64'h00CCBBAA);
    check("pf_keep", 64'(m_keep), 64'h7);
    check("pf_busy", 64'(flush_busy), 64'd1);
    repeat (3) @(negedge r_clk);
    check("pf_busy_hold", 64'(flush_busy), 64'd1);
    check("pf_valid_hold", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    @(negedge r_clk);
    check("pf_busy_clr", 64'(flush_busy), 64'd0);
    check("pf_valid_clr", 64'(m_valid), 64'd0);
    check("pf_word", 64'(words[w0]), 64'h7_00CCBBAA);
    check("pf_count", 64'(wcount - w0), 64'd1);

    // Flush with nothing packed.
    check("ef_byte_cnt", 64'(byte_cnt), 64'd0);
    w0 = wcount;
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    busy_n = 0;
    v_n = 0;
    repeat (8) begin
      if (flush_busy) busy_n++;
      if (m_valid) v_n++;
      @(negedge r_clk);
    end
    check("ef_busy_cycles", 64'(busy_n), 64'd2);
    check("ef_no_valid", 64'(v_n), 64'd0);
    check("ef_no_word", 64'(wcount - w0), 64'd0);

    // Sporadic writes with the FIFO running empty in between.
    gb = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    gg = '{3, 2, 0, 4, 1, 3, 2, 1};
    w0 = wcount;
    for (int i = 0; i < 8; i++) begin
      push(gb[i]);
      repeat (gg[i] + 1) @(negedge r_clk);
    end
    wait_words(w0 + 2);
    check("gap_w0", 64'(words[w0]), 64'hF_24232221);
    check("gap_w1", 64'(words[w0+1]), 64'hF_28272625);

    // Reset in the middle of a word.
    w0 = wcount;
    push(8'h31);
    push(8'h32);
    repeat (5) @(negedge r_clk);
    check("mr_pre_cnt", 64'(byte_cnt), 64'd2);
    rrst = 1'b1;
    @(negedge r_clk);
    rrst = 1'b0;
    check("mr_byte_cnt", 64'(byte_cnt), 64'd0);
    check("mr_valid", 64'(m_valid), 64'd0);
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
    wait_words(w0 + 1);
    check("mr_word", 64'(words[w0]), 64'hF_44434241);
    repeat (10) @(negedge r_clk);
    check("mr_count", 64'(wcount - w0), 64'd1);

    check("r_en_while_empty", 64'(en_empty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
